// File: rtl/ser2par_pkg.sv
// ser2par_pkg: FSM states and width helper shared by the ser2par arbiter files.
package ser2par_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, STREAM, DRAIN, FLUSH} state_t;
  localparam int OUT_W = 4;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ser2par_arbiter_rr_pick.sv
// rr_pick: first requesting lane at or after ptr, wrapping past NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] k;
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr) + i) % NUM_REQ);
      idx = req[k] ? k : idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/ser2par_arbiter.sv
// ser2par_arbiter: frame-by-frame round-robin sharing of one ser2par deserializer,
// tagging returned words with lane ID / end-of-frame and flushing broken frames.
module ser2par_arbiter
  import ser2par_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LENGTH = 8,
  parameter int DRAIN_TIMEOUT = 4,
  parameter int ID_W = clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] s_req,
  input  logic [NUM_REQ-1:0] s_valid,
  input  logic [NUM_REQ-1:0] s_data,
  input  logic [NUM_REQ-1:0] s_last,
  output logic [NUM_REQ-1:0] s_gnt,
  output logic               par_ivalid,
  output logic               par_idata,
  output logic               par_flush,
  input  logic               par_ovalid,
  input  logic [LENGTH-1:0]  par_odata,
  output logic               m_valid,
  output logic [LENGTH-1:0]  m_data,
  output logic [ID_W-1:0]    m_id,
  output logic               m_last,
  output logic               err_partial,
  output logic               err_timeout
);
  localparam int CNT_W = clog2(LENGTH);
  localparam int TMR_W = clog2(DRAIN_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d, rr_ptr_q, rr_ptr_d, pick_idx, nxt_id;
  logic               pick_any, acc, wrap, ret;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] s_gnt_q, s_gnt_d;
  logic               par_flush_q, par_flush_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic               err_partial_q, err_partial_d, err_timeout_q, err_timeout_d;
  logic [LENGTH-1:0]  m_data_q, m_data_d;
  logic [ID_W-1:0]    m_id_q, m_id_d;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(s_req),
    .ptr(rr_ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign acc = enable && state_q == STREAM && s_valid[cur_id_q];
  assign wrap = bit_cnt_q == CNT_W'(LENGTH - 1);
  assign ret = enable && par_ovalid;
  assign nxt_id = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
  assign par_ivalid = acc;
  assign par_idata = state_q == STREAM && s_data[cur_id_q];
  assign s_gnt = s_gnt_q;
  assign par_flush = par_flush_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_id = m_id_q;
  assign m_last = m_last_q;
  assign err_partial = err_partial_q;
  assign err_timeout = err_timeout_q;

  always_comb begin
    state_d = state_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    bit_cnt_d = acc ? (wrap ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
    // underflow guard: a stray ovalid with nothing outstanding must not wrap the count
    outstanding_d = outstanding_q + OUT_W'(acc && wrap) - OUT_W'(ret && outstanding_q != '0);
    timer_d = '0;
    s_gnt_d = s_gnt_q;
    par_flush_d = 1'b0;
    err_partial_d = 1'b0;
    err_timeout_d = 1'b0;
    m_valid_d = ret;
    m_data_d = ret ? par_odata : m_data_q;
    m_id_d = ret ? cur_id_q : m_id_q;
    m_last_d = ret && state_q == DRAIN && outstanding_q == OUT_W'(1);
    case (state_q)
      IDLE: if (pick_any) begin
        cur_id_d = pick_idx;
        s_gnt_d = NUM_REQ'(1) << pick_idx;
        state_d = GRANT;
      end
      GRANT: state_d = STREAM;
      STREAM: if (acc && s_last[cur_id_q]) begin
        s_gnt_d = '0;
        err_partial_d = !wrap;
        state_d = wrap ? DRAIN : FLUSH;
      end
      DRAIN: if (outstanding_d == '0) begin
        rr_ptr_d = nxt_id;
        state_d = IDLE;
      end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
        err_timeout_d = 1'b1;
        state_d = FLUSH;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      FLUSH: begin
        par_flush_d = 1'b1;
        outstanding_d = '0;
        bit_cnt_d = '0;
        rr_ptr_d = nxt_id;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_id_q <= '0;
      rr_ptr_q <= '0;
      bit_cnt_q <= '0;
      outstanding_q <= '0;
      timer_q <= '0;
      s_gnt_q <= '0;
      par_flush_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_id_q <= '0;
      m_last_q <= 1'b0;
      err_partial_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      outstanding_q <= outstanding_d;
      timer_q <= timer_d;
      s_gnt_q <= s_gnt_d;
      par_flush_q <= par_flush_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_id_q <= m_id_d;
      m_last_q <= m_last_d;
      err_partial_q <= err_partial_d;
      err_timeout_q <= err_timeout_d;
    end
  end
endmodule

// File: tb/tb_ser2par_arbiter.sv
// tb_ser2par_arbiter: directed self-checking bench; the deserializer is a behavioural
// ser2par (LENGTH=8, MSB-first) whose final-word ovalid can be suppressed.
`timescale 1ns/1ps
module tb_ser2par_arbiter;
  localparam int N = 4;
  localparam int L = 8;

  logic clock = 0, reset = 0, enable = 1;
  logic [N-1:0] s_req = '0, s_valid = '0, s_data = '0, s_last = '0, s_gnt;
  logic par_ivalid, par_idata, par_flush, par_ovalid, m_valid, m_last, err_partial, err_timeout;
  logic [L-1:0] par_odata, m_data;
  logic [1:0] m_id;
  int checks = 0, failures = 0, pause_leak = 0, cyc = 0;

  ser2par_arbiter #(.NUM_REQ(N), .LENGTH(L), .DRAIN_TIMEOUT(4), .ID_W(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_req(s_req), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_gnt(s_gnt),
    .par_ivalid(par_ivalid), .par_idata(par_idata), .par_flush(par_flush),
    .par_ovalid(par_ovalid), .par_odata(par_odata),
    .m_valid(m_valid), .m_data(m_data), .m_id(m_id), .m_last(m_last),
    .err_partial(err_partial), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [L-1:0] sh, od;
  int dcnt;
  logic ov;
  logic sup = 0;
  always @(posedge clock or posedge reset)
    if (reset) begin
      dcnt <= 0; ov <= 1'b0; sh <= '0; od <= '0;
    end else if (par_flush) begin
      dcnt <= 0; ov <= 1'b0;
    end else begin
      ov <= 1'b0;
      if (par_ivalid) begin
        sh <= {sh[L-2:0], par_idata};
        dcnt <= (dcnt == L - 1) ? 0 : dcnt + 1;
        if (dcnt == L - 1) begin
          ov <= !sup;
          od <= {sh[L-2:0], par_idata};
        end
      end
    end
  assign par_ovalid = ov;
  assign par_odata = od;

  logic [L-1:0] qd[$];
  logic [1:0] qi[$];
  logic ql[$];
  logic [N-1:0] qg[$];
  int gaps[$];
  int n_part = 0, n_tmo = 0, n_flush = 0, part_cyc = 0, tmo_cyc = 0, flush_cyc = 0, fall_cyc = 0, low_run = 0;
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clock) begin
    if (m_valid) begin qd.push_back(m_data); qi.push_back(m_id); ql.push_back(m_last); end
    if (err_partial) begin n_part <= n_part + 1; part_cyc <= cyc; end
    if (err_timeout) begin n_tmo <= n_tmo + 1; tmo_cyc <= cyc; end
    if (par_flush) begin n_flush <= n_flush + 1; flush_cyc <= cyc; end
    if (s_gnt != '0 && prev_gnt == '0) begin qg.push_back(s_gnt); gaps.push_back(low_run); end
    if (s_gnt == '0 && prev_gnt != '0) fall_cyc <= cyc;
    low_run <= (s_gnt == '0) ? low_run + 1 : 0;
    prev_gnt <= s_gnt;
  end

  task automatic do_reset();
    s_req = '0; s_valid = '0; s_data = '0; s_last = '0; enable = 1; sup = 0;
    #1 reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [1:0] lane, input int nbits, input logic [15:0] bits,
                            input bit bubbles, input int pause_at, input bit drop);
    logic [15:0] sb;
    int t;
    sb = bits << (16 - nbits);
    t = 0;
    while (!s_gnt[lane] && t < 60) begin @(negedge clock); t++; end
    if (!s_gnt[lane]) begin
      checks++; failures++;
      $display("FAIL grant_wait lane %0d: s_gnt=%b, required bit %0d set", lane, s_gnt, lane);
      return;
    end
    if (drop) s_req = '0;
    @(negedge clock);
    for (int b = 0; b < nbits; b++) begin
      if (bubbles) begin s_valid[lane] = 0; s_last[lane] = 0; @(negedge clock); end
      s_valid[lane] = 1; s_data[lane] = sb[15]; s_last[lane] = (b == nbits - 1);
      sb = sb << 1;
      if (b == pause_at) begin
        enable = 0;
        repeat (3) begin #1 if (par_ivalid) pause_leak++; @(negedge clock); end
        enable = 1;
      end
      @(negedge clock);
    end
    s_valid[lane] = 0; s_last[lane] = 0; s_data[lane] = 0;
  endtask

  task automatic test_reset();
    s_valid = '1; s_data = '1;
    #1 reset = 1;
    @(negedge clock);
    checks++;
    if ({s_gnt, par_flush, m_valid, m_last, err_partial, err_timeout} !== '0) begin
      failures++; $display("FAIL reset_ctrl: got %b, required 0", {s_gnt, par_flush, m_valid, m_last, err_partial, err_timeout});
    end
    checks++;
    if ({m_data, m_id} !== '0) begin failures++; $display("FAIL reset_data: got %h, required 0", {m_data, m_id}); end
    checks++;
    if ({par_ivalid, par_idata} !== 2'b00) begin failures++; $display("FAIL reset_par: got %b, required 00", {par_ivalid, par_idata}); end
    reset = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({s_gnt, par_ivalid} !== '0) begin failures++; $display("FAIL idle_no_req: got %b, required 0", {s_gnt, par_ivalid}); end
    s_valid = '0; s_data = '0;
  endtask

  task automatic test_single_frame();
    int b0, p0, t0;
    do_reset();
    b0 = qd.size(); p0 = n_part; t0 = n_tmo;
    s_req = 4'b0001;
    send_frame(2'd0, 16, 16'hD53C, 0, -1, 1);
    repeat (4) @(negedge clock);
    checks++;
    if (qd.size() - b0 != 2) begin failures++; $display("FAIL single_count: got %0d words, required 2", qd.size() - b0); end
    if (qd.size() - b0 >= 2) begin
      checks++;
      if ({qd[b0], qi[b0], ql[b0]} !== {8'hD5, 2'd0, 1'b0}) begin
        failures++; $display("FAIL single_w0: got %h/%0d/%b, required d5/0/0", qd[b0], qi[b0], ql[b0]);
      end
      checks++;
      if ({qd[b0+1], qi[b0+1], ql[b0+1]} !== {8'h3C, 2'd0, 1'b1}) begin
        failures++; $display("FAIL single_w1: got %h/%0d/%b, required 3c/0/1", qd[b0+1], qi[b0+1], ql[b0+1]);
      end
    end
    checks++;
    if (n_part - p0 != 0 || n_tmo - t0 != 0) begin
      failures++; $display("FAIL single_err: got partial=%0d timeout=%0d, required 0/0", n_part - p0, n_tmo - t0);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] wd[5];
    logic [1:0] wl[5];
    int b0, g0;
    wd = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
    wl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    b0 = qd.size(); g0 = qg.size();
    s_req = 4'b1111;
    for (int f = 0; f < 5; f++) send_frame(wl[f], 8, {8'h00, wd[f]}, 0, -1, f == 4);
    repeat (4) @(negedge clock);
    checks++;
    if (qg.size() - g0 != 5 || qd.size() - b0 != 5) begin
      failures++; $display("FAIL rr_count: got %0d grants %0d words, required 5/5", qg.size() - g0, qd.size() - b0);
    end
    for (int f = 0; f < 5; f++) begin
      if (qg.size() > g0 + f) begin
        checks++;
        if (qg[g0+f] !== N'(1) << wl[f]) begin failures++; $display("FAIL rr_grant%0d: got %b, required lane %0d", f, qg[g0+f], wl[f]); end
        if (f > 0) begin
          checks++;
          if (gaps[g0+f] < 2) begin failures++; $display("FAIL rr_gap%0d: got %0d idle cycles, required >=2", f, gaps[g0+f]); end
        end
      end
      if (qd.size() > b0 + f) begin
        checks++;
        if ({qd[b0+f], qi[b0+f], ql[b0+f]} !== {wd[f], wl[f], 1'b1}) begin
          failures++; $display("FAIL rr_word%0d: got %h/%0d/%b, required %h/%0d/1", f, qd[b0+f], qi[b0+f], ql[b0+f], wd[f], wl[f]);
        end
      end
    end
  endtask

  task automatic test_bubbles_enable();
    int b0, p0;
    do_reset();
    b0 = qd.size(); p0 = n_part; pause_leak = 0;
    s_req = 4'b0100;
    send_frame(2'd2, 8, 16'h00B6, 1, 4, 1);
    repeat (4) @(negedge clock);
    checks++;
    if (pause_leak != 0) begin failures++; $display("FAIL enable_ivalid: got %0d ivalid cycles while disabled, required 0", pause_leak); end
    checks++;
    if (qd.size() - b0 != 1) begin failures++; $display("FAIL bubble_count: got %0d words, required 1", qd.size() - b0); end
    if (qd.size() - b0 >= 1) begin
      checks++;
      if ({qd[b0], qi[b0], ql[b0]} !== {8'hB6, 2'd2, 1'b1}) begin
        failures++; $display("FAIL bubble_word: got %h/%0d/%b, required b6/2/1", qd[b0], qi[b0], ql[b0]);
      end
    end
    checks++;
    if (n_part != p0) begin failures++; $display("FAIL bubble_err: got %0d partial, required 0", n_part - p0); end
  endtask

  task automatic test_partial();
    int b0, p0, f0;
    do_reset();
    b0 = qd.size(); p0 = n_part; f0 = n_flush;
    s_req = 4'b0010;
    send_frame(2'd1, 5, 16'h0015, 0, -1, 1);
    s_req = 4'b0101;
    for (int t = 0; t < 20 && s_gnt == '0; t++) @(negedge clock);
    checks++;
    if (s_gnt !== 4'b0100) begin failures++; $display("FAIL partial_next: got %b, required 0100", s_gnt); end
    checks++;
    if (n_part - p0 != 1 || n_flush - f0 != 1) begin
      failures++; $display("FAIL partial_pulses: got partial=%0d flush=%0d, required 1/1", n_part - p0, n_flush - f0);
    end
    checks++;
    if (part_cyc != fall_cyc || flush_cyc != part_cyc + 1) begin
      failures++; $display("FAIL partial_timing: got gnt_drop=%0d partial=%0d flush=%0d, required partial=drop, flush=partial+1", fall_cyc, part_cyc, flush_cyc);
    end
    checks++;
    if (qd.size() != b0) begin failures++; $display("FAIL partial_words: got %0d, required 0", qd.size() - b0); end
  endtask

  task automatic test_timeout();
    int b0, t0, f0, p0;
    do_reset();
    b0 = qd.size(); t0 = n_tmo; f0 = n_flush; p0 = n_part;
    sup = 1;
    s_req = 4'b0001;
    send_frame(2'd0, 8, 16'h0077, 0, -1, 1);
    repeat (7) @(negedge clock);
    sup = 0;
    checks++;
    if (n_tmo - t0 != 1 || n_flush - f0 != 1 || n_part != p0) begin
      failures++; $display("FAIL tmo_pulses: got timeout=%0d flush=%0d partial=%0d, required 1/1/0", n_tmo - t0, n_flush - f0, n_part - p0);
    end
    checks++;
    if (tmo_cyc - fall_cyc != 4) begin failures++; $display("FAIL tmo_delay: got %0d drain cycles, required 4", tmo_cyc - fall_cyc); end
    checks++;
    if (flush_cyc != tmo_cyc + 1) begin failures++; $display("FAIL tmo_flush: got flush at +%0d, required +1", flush_cyc - tmo_cyc); end
    checks++;
    if (qd.size() != b0) begin failures++; $display("FAIL tmo_words: got %0d, required 0", qd.size() - b0); end
    s_req = 4'b0010;
    for (int t = 0; t < 20 && s_gnt == '0; t++) @(negedge clock);
    checks++;
    if (s_gnt !== 4'b0010) begin failures++; $display("FAIL tmo_idle: got %b, required 0010", s_gnt); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    s_req = 4'b1000;
    for (int t = 0; t < 20 && s_gnt == '0; t++) @(negedge clock);
    s_req = '0;
    @(negedge clock);
    for (int b = 0; b < 4; b++) begin s_valid[3] = 1; s_data[3] = b[0]; @(negedge clock); end
    s_valid[3] = 1; s_data[3] = 1;
    #1;
    checks++;
    if ({s_gnt, par_ivalid, par_idata} !== 6'b100011) begin
      failures++; $display("FAIL mid_stream: got %b, required 100011", {s_gnt, par_ivalid, par_idata});
    end
    #1 reset = 1;
    #1;
    checks++;
    if ({s_gnt, par_ivalid, par_idata, par_flush, m_valid, m_last, err_partial, err_timeout, m_data, m_id} !== '0) begin
      failures++; $display("FAIL async_reset: got %b, required 0", {s_gnt, par_ivalid, par_idata, par_flush, m_valid, m_last, err_partial, err_timeout, m_data, m_id});
    end
    @(negedge clock);
    reset = 0; s_valid = '0; s_data = '0;
    s_req = 4'b1001;
    for (int t = 0; t < 20 && s_gnt == '0; t++) @(negedge clock);
    checks++;
    if (s_gnt !== 4'b0001) begin failures++; $display("FAIL post_reset_grant: got %b, required 0001", s_gnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_bubbles_enable();
    test_partial();
    test_timeout();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000ns");
    $fatal(1);
  end
endmodule

// File: doc/ser2par_arbiter.md
Name: ser2par_arbiter

Overview:
- Shares one ser2par deserializer (LENGTH-bit word) among NUM_REQ serial bit-stream requesters.
- Grants the deserializer frame-by-frame in round-robin order and muxes the granted lane's bits into it.
- Tags each returned parallel word with the source lane ID and end-of-frame.
- Flushes and flags frames that end mid-word or whose final word never returns.

Parameters:
NUM_REQ, 4, number of serial requesters (2..8)
LENGTH, 8, deserializer word width in bits; must match the ser2par instance
DRAIN_TIMEOUT, 4, cycles to wait in DRAIN for outstanding words before flagging an error
ID_W, 2, width of lane ID (clog2(NUM_REQ))

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global clock enable; low freezes all state
s_req  in  NUM_REQ  per-lane frame request; held until granted
s_valid  in  NUM_REQ  per-lane bit valid
s_data  in  NUM_REQ  per-lane serial bit
s_last  in  NUM_REQ  per-lane last bit of frame; qualified by s_valid
s_gnt  out  NUM_REQ  one-hot grant; high from GRANT through the last accepted bit
par_ivalid  out  1  to deserializer ivalid
par_idata  out  1  to deserializer idata
par_flush  out  1  one-cycle synchronous clear pulse to the deserializer
par_ovalid  in  1  from deserializer ovalid
par_odata  in  LENGTH  from deserializer odata
m_valid  out  1  parallel word valid; equals par_ovalid registered
m_data  out  LENGTH  parallel word
m_id  out  ID_W  lane that produced m_data
m_last  out  1  m_data is the final word of its frame
err_partial  out  1  one-cycle pulse: frame ended with bit count not a multiple of LENGTH
err_timeout  out  1  one-cycle pulse: DRAIN_TIMEOUT expired with words outstanding

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all counters 0; s_gnt, par_ivalid, par_idata, par_flush, m_valid, m_data, m_id, m_last, err_* all 0.
- enable=0: no state, counter or output register changes; par_ivalid forced 0 combinationally.
- States: IDLE, GRANT, STREAM, DRAIN, FLUSH.
- IDLE:
  - If any s_req is set, pick the first requesting lane at or after rr_ptr (wrapping), latch it as cur_id, and go to GRANT.
  - If no s_req is set, stay in IDLE.
- GRANT: s_gnt[cur_id]=1 for one cycle, then STREAM. Gives the requester one cycle of notice.
- STREAM:
  - Combinational outputs: par_ivalid = s_valid[cur_id], par_idata = s_data[cur_id].
  - Bubbles are allowed; non-granted lanes are ignored.
  - bit_cnt counts accepted bits modulo LENGTH. On wrap to 0, outstanding increments.
  - On an accepted bit with s_last: drop s_gnt next cycle. If bit_cnt after the increment is 0, go to DRAIN; otherwise pulse err_partial and go to FLUSH.
- Return path (all states):
  - When par_ovalid=1, register m_valid=1, m_data=par_odata, m_id=cur_id, and decrement outstanding.
  - m_last=1 when state is DRAIN and outstanding==1 before the decrement.
  - Output latency is 1 cycle after par_ovalid.
  - Simultaneous increment and decrement of outstanding leaves it unchanged.
- DRAIN:
  - When outstanding reaches 0, set rr_ptr=cur_id+1 (wrap at NUM_REQ) and go to IDLE.
  - Timer counts up to DRAIN_TIMEOUT. On expiry with outstanding>0, pulse err_timeout and go to FLUSH.
- FLUSH: pulse par_flush for one cycle, clear outstanding and bit_cnt, advance rr_ptr, go to IDLE.
- Minimum gap between frames: one IDLE cycle plus one GRANT cycle.
- Fairness: no lane is granted twice while another lane has s_req pending.
- Async reset mid-frame: immediate return to reset values. The requester must re-request.

Decomposition:
- Package ser2par_pkg: state enum (IDLE, GRANT, STREAM, DRAIN, FLUSH) and a clog2 function for ID_W and counter widths.
- Sub-module rr_pick: combinational round-robin first-set-from-pointer picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: index, any.

Test Plan:
- Single frame: lane 0 sends 16 bits 0xD5,0x3C (each MSB-first), s_last on bit 16, deserializer modelled as ser2par LENGTH=8 -> two m_valid words, m_id=0, m_last only on the second word, no err.
- Round robin: s_req=4'b1111 held, each lane sends one 8-bit frame -> grants in order 0,1,2,3,0; m_id sequence matches; at least 2 idle cycles between frames.
- Bubbles and enable: lane 2 sends 8 bits with s_valid low every other cycle and enable low for 3 cycles mid-frame -> one correct word, m_id=2, bit_cnt frozen while enable=0.
- Partial frame: lane 1 asserts s_last on bit 5 -> err_partial pulse, par_flush pulse next cycle, no m_valid, next grant goes to lane 2.
- Timeout: deserializer model suppresses ovalid for the final word -> err_timeout after 4 DRAIN cycles, then par_flush, then return to IDLE.
- Reset mid-STREAM: assert reset at bit 4 of lane 3 -> all outputs 0 asynchronously; after release rr_ptr=0, so lane 0 is granted first.
